// File: rtl/fetch_sequencer.sv
// fetch_sequencer: loads a program from the UART byte stream into instruction
// memory, then gates PC/pipeline advance in continuous or single-step mode.
module fetch_sequencer #(
  parameter int          ADDR_W    = 8,
  parameter int          ADDR_STEP = 1,
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_done,
  input  logic              i_halt,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_data,
  output logic              o_pipe_enable,
  output logic [2:0]        o_state,
  output logic              o_load_err,
  output logic              o_done
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOAD      = 3'd1;
  localparam logic [2:0] WRITE     = 3'd2;
  localparam logic [2:0] WAIT_CMD  = 3'd3;
  localparam logic [2:0] RUN       = 3'd4;
  localparam logic [2:0] STEP_WAIT = 3'd5;
  localparam logic [2:0] STEP      = 3'd6;
  localparam logic [2:0] DONE      = 3'd7;

  localparam logic [7:0] CMD_L = 8'h4C;
  localparam logic [7:0] CMD_C = 8'h43;
  localparam logic [7:0] CMD_S = 8'h53;
  localparam logic [7:0] CMD_N = 8'h4E;
  localparam logic [7:0] CMD_R = 8'h52;

  localparam logic [ADDR_W:0] STEP_W = (ADDR_W+1)'(ADDR_STEP);

  logic [2:0]        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       word_q, word_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              pe_q, pe_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [31:0]       shift_word;
  logic [ADDR_W:0]   addr_sum;
  logic              addr_last;

  // Byte shifted into the word register MSB first; carry bit of the next
  // address flags the last slot so the address itself never wraps.
  always_comb begin
    shift_word = {word_q[23:0], i_rx_data};
    addr_sum   = {1'b0, addr_q} + STEP_W;
    addr_last  = addr_sum[ADDR_W];
  end

  // Next-state and datapath update; memory write outputs are computed here so
  // they register together with the write enable.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    word_d  = word_q;
    err_d   = err_q;
    we_d    = 1'b0;
    waddr_d = '0;
    wdata_d = '0;

    case (state_q)
      IDLE: begin
        if (i_rx_done && i_rx_data == CMD_L) begin
          state_d = LOAD;
          addr_d  = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (i_rx_done) begin
          word_d = shift_word;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = WRITE;
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = shift_word;
          end
        end
      end
      WRITE: begin
        // A byte landing in the write cycle starts the next word right away.
        if (i_rx_done) begin
          word_d = shift_word;
          cnt_d  = cnt_q + 2'd1;
        end
        if (word_q == HALT_WORD) begin
          state_d = WAIT_CMD;
        end else if (addr_last) begin
          state_d = WAIT_CMD;
          err_d   = 1'b1;
        end else begin
          state_d = LOAD;
          addr_d  = addr_sum[ADDR_W-1:0];
        end
      end
      WAIT_CMD: begin
        if (i_rx_done) begin
          if (i_rx_data == CMD_C) state_d = RUN;
          else if (i_rx_data == CMD_S) state_d = STEP_WAIT;
          else if (i_rx_data == CMD_L) begin
            state_d = LOAD;
            addr_d  = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
          end
        end
      end
      RUN: begin
        if (i_halt) state_d = DONE;
      end
      STEP_WAIT: begin
        // Halt has priority; a coincident byte is dropped.
        if (i_halt) state_d = DONE;
        else if (i_rx_done && i_rx_data == CMD_N) state_d = STEP;
        else if (i_rx_done && i_rx_data == CMD_C) state_d = RUN;
      end
      STEP: begin
        if (i_halt) state_d = DONE;
        else        state_d = STEP_WAIT;
      end
      DONE: begin
        if (i_rx_done && i_rx_data == CMD_R) state_d = IDLE;
        else if (i_rx_done && i_rx_data == CMD_L) begin
          state_d = LOAD;
          addr_d  = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Status outputs follow the registered state in the same cycle.
    pe_d   = (state_d == RUN) || (state_d == STEP);
    done_d = (state_d == DONE);
  end

  // State and output registers; reset aborts any load or run immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      word_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      pe_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      pe_q    <= pe_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign o_imem_we     = we_q;
  assign o_imem_addr   = waddr_q;
  assign o_imem_data   = wdata_q;
  assign o_pipe_enable = pe_q;
  assign o_state       = state_q;
  assign o_load_err    = err_q;
  assign o_done        = done_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a default instance plus a 2-bit address
// instance sharing the same stimulus, used for the overflow case.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       halt = 1'b0;

  logic       we, pe, load_err, done;
  logic [7:0] addr;
  logic [31:0] data;
  logic [2:0] state;

  logic       we2, pe2, load_err2, done2;
  logic [1:0] addr2;
  logic [31:0] data2;
  logic [2:0] state2;

  int checks = 0;
  int errors = 0;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .i_rx_data(rx_data), .i_rx_done(rx_done), .i_halt(halt),
    .o_imem_we(we), .o_imem_addr(addr), .o_imem_data(data), .o_pipe_enable(pe),
    .o_state(state), .o_load_err(load_err), .o_done(done)
  );

  fetch_sequencer #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst(rst), .i_rx_data(rx_data), .i_rx_done(rx_done), .i_halt(halt),
    .o_imem_we(we2), .o_imem_addr(addr2), .o_imem_data(data2), .o_pipe_enable(pe2),
    .o_state(state2), .o_load_err(load_err2), .o_done(done2)
  );

  always #5 clk = ~clk;

  // Write / enable monitors, sampled on the falling edge.
  logic [31:0] wa [64];
  logic [31:0] wd [64];
  logic [31:0] wa2 [64];
  logic [31:0] wd2 [64];
  int wcnt = 0, w2cnt = 0, pe_hi = 0, pe_rise = 0, bad_we = 0;
  logic pe_prev = 1'b0;

  always @(negedge clk) begin
    if (we) begin
      wa[wcnt % 64] <= {24'd0, addr};
      wd[wcnt % 64] <= data;
      wcnt <= wcnt + 1;
    end
    if (we2) begin
      wa2[w2cnt % 64] <= {30'd0, addr2};
      wd2[w2cnt % 64] <= data2;
      w2cnt <= w2cnt + 1;
    end
    if ((we && state != 3'd2) || (we2 && state2 != 3'd2)) bad_we <= bad_we + 1;
    if (pe) pe_hi <= pe_hi + 1;
    if (pe && !pe_prev) pe_rise <= pe_rise + 1;
    pe_prev <= pe;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  int base, base2, hbase, rbase;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_pe", {31'd0, pe}, 32'd0);
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, load_err}, 32'd0);
    rst = 1'b0;

    // Program load: two words, second one is the halt word
    hbase = pe_hi;
    base  = wcnt;
    send(8'h4C);
    send(8'h20); send(8'h08); send(8'h00); send(8'h05);
    send(8'hFF); send(8'hFF); send(8'hFF); send(8'hFF);
    repeat (3) @(negedge clk);
    chk("load_wcnt", wcnt - base, 32'd2);
    chk("load_a0", wa[base % 64], 32'd0);
    chk("load_d0", wd[base % 64], 32'h20080005);
    chk("load_a1", wa[(base + 1) % 64], 32'd1);
    chk("load_d1", wd[(base + 1) % 64], 32'hFFFFFFFF);
    chk("load_state", {29'd0, state}, 32'd3);
    chk("load_err", {31'd0, load_err}, 32'd0);
    chk("load_pe", pe_hi - hbase, 32'd0);

    // Continuous run, halt pulse ten cycles in
    hbase = pe_hi;
    send(8'h43);
    @(negedge clk);
    chk("run_pe", {31'd0, pe}, 32'd1);
    chk("run_state", {29'd0, state}, 32'd4);
    repeat (9) @(posedge clk);
    #1 halt = 1'b1;
    @(posedge clk); #1 halt = 1'b0;
    @(negedge clk);
    chk("halt_pe", {31'd0, pe}, 32'd0);
    chk("halt_done", {31'd0, done}, 32'd1);
    chk("halt_state", {29'd0, state}, 32'd7);
    chk("run_pe_cycles", pe_hi - hbase, 32'd10);

    // Reload from DONE with just a halt word, then single-step
    send(8'h4C);
    send(8'hFF); send(8'hFF); send(8'hFF); send(8'hFF);
    repeat (2) @(negedge clk);
    chk("reload_state", {29'd0, state}, 32'd3);
    chk("reload_done", {31'd0, done}, 32'd0);
    send(8'h53);
    @(negedge clk);
    chk("stepw_state", {29'd0, state}, 32'd5);
    chk("stepw_pe", {31'd0, pe}, 32'd0);
    hbase = pe_hi;
    rbase = pe_rise;
    for (int i = 0; i < 3; i++) begin
      repeat (20) @(posedge clk);
      send(8'h4E);
    end
    repeat (3) @(negedge clk);
    chk("step_pulses", pe_rise - rbase, 32'd3);
    chk("step_pe_cycles", pe_hi - hbase, 32'd3);
    chk("step_back_state", {29'd0, state}, 32'd5);
    send(8'h43);
    @(negedge clk);
    chk("step_run_pe", {31'd0, pe}, 32'd1);
    repeat (5) @(negedge clk);
    chk("step_run_hold", {31'd0, pe}, 32'd1);
    chk("step_run_state", {29'd0, state}, 32'd4);

    // Halt and byte in the same cycle: halt wins
    rbase = pe_rise;
    @(posedge clk); #1;
    halt = 1'b1; rx_data = 8'h4E; rx_done = 1'b1;
    @(posedge clk); #1;
    halt = 1'b0; rx_done = 1'b0;
    @(negedge clk);
    chk("coll_state", {29'd0, state}, 32'd7);
    chk("coll_done", {31'd0, done}, 32'd1);
    chk("coll_pe", {31'd0, pe}, 32'd0);
    repeat (5) @(negedge clk);
    chk("coll_no_step", pe_rise - rbase, 32'd0);
    send(8'h52);
    @(negedge clk);
    chk("r_state", {29'd0, state}, 32'd0);
    chk("r_done", {31'd0, done}, 32'd0);

    // Asynchronous reset in the middle of a load
    send(8'h4C); send(8'h11); send(8'h22);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("arst_state", {29'd0, state}, 32'd0);
    chk("arst_pe", {31'd0, pe}, 32'd0);
    chk("arst_we", {31'd0, we}, 32'd0);
    chk("arst_addr", {24'd0, addr}, 32'd0);
    chk("arst_data", data, 32'd0);
    @(negedge clk) rst = 1'b0;
    base = wcnt;
    send(8'h4C);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    repeat (3) @(negedge clk);
    chk("arst_wcnt", wcnt - base, 32'd1);
    chk("arst_a0", wa[base % 64], 32'd0);
    chk("arst_d0", wd[base % 64], 32'hAABBCCDD);
    chk("arst_load_state", {29'd0, state}, 32'd1);

    // Overflow on the 2-bit address instance
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    base2 = w2cnt;
    send(8'h4C);
    for (int i = 0; i < 16; i++)
      for (int k = 0; k < 4; k++)
        send(8'(i));
    repeat (3) @(negedge clk);
    chk("ovf_wcnt", w2cnt - base2, 32'd4);
    chk("ovf_a0", wa2[base2 % 64], 32'd0);
    chk("ovf_d0", wd2[base2 % 64], 32'h00000000);
    chk("ovf_a3", wa2[(base2 + 3) % 64], 32'd3);
    chk("ovf_d3", wd2[(base2 + 3) % 64], 32'h03030303);
    chk("ovf_err", {31'd0, load_err2}, 32'd1);
    chk("ovf_state", {29'd0, state2}, 32'd3);

    chk("we_only_in_write", bad_we, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
